// File: rtl/paged_mem_bridge.sv
`default_nettype none
// ============================================================================
// paged_mem_bridge : TI-99/4A memory cycles -> page-mapped 16-bit SRAM bytes
// Optional feature macro: PAGE_READONLY_EN (drops writes to readonly pages)
// Rev 1.0
// ============================================================================
module paged_mem_bridge #(
  parameter int PAGE_BITS = 4,
  parameter int PHYS_BITS = 7,
  parameter int RD_WAIT   = 2,
  parameter int WE_PULSE  = 2,
  localparam int SRAM_AW  = PHYS_BITS + 15 - PAGE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memen,
  input  logic                 dbin,
  input  logic                 we,
  input  logic                 a15,
  input  logic [15:0]          i_addr,
  input  logic                 i_addr_valid,
  input  logic [7:0]           i_data_bus,
  output logic [7:0]           o_data_bus,
  output logic                 o_dbdir,
  input  logic                 i_map_wr,
  input  logic [PAGE_BITS-1:0] i_map_idx,
  input  logic [PHYS_BITS+1:0] i_map_data,
  output logic [SRAM_AW-1:0]   o_sram_addr,
  output logic [15:0]          o_sram_data,
  input  logic [15:0]          i_sram_data,
  output logic                 o_sram_oe_data,
  output logic                 RAMCS,
  output logic                 RAMOE,
  output logic                 RAMWE,
  output logic                 RAMUB,
  output logic                 RAMLB,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  localparam int OFF_W   = 15 - PAGE_BITS;
  localparam int ENTRIES = 2 ** PAGE_BITS;
  localparam int VLD     = PHYS_BITS + 1;
  localparam int RO      = PHYS_BITS;
  localparam logic [3:0] RD_LAST    = 4'(RD_WAIT - 1);
  localparam logic [3:0] PULSE_LAST = 4'(WE_PULSE - 1);
  localparam logic [3:0] PULSE_END  = 4'(WE_PULSE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ADDR = 3'd1,
    S_DECODE    = 3'd2,
    S_READ      = 3'd3,
    S_WRITE     = 3'd4,
    S_WPULSE    = 3'd5,
    S_HOLD      = 3'd6
  } state_t;

  state_t                 state_q;
  logic [3:0]             sync1_q, sync2_q;
  logic [3:0]             cnt_q;
  logic [OFF_W-1:0]       off_q;
  logic [PHYS_BITS+1:0]   ent_q;
  logic [15:0]            rdata_q;
  logic                   we_arm_q;
  logic [PHYS_BITS+1:0]   table_q [ENTRIES];

  logic                   memen_s, dbin_s, we_s, a15_s;
  logic                   we_ok;
  logic [PAGE_BITS-1:0]   page;
  logic                   unused_ok;

  // Sync order {memen, dbin, we, a15}; idle levels are memen/we high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1010;
      sync2_q <= 4'b1010;
    end else begin
      sync1_q <= {memen, dbin, we, a15};
      sync2_q <= sync1_q;
    end
  end

  assign memen_s = sync2_q[3];
  assign dbin_s  = sync2_q[2];
  assign we_s    = sync2_q[1];
  assign a15_s   = sync2_q[0];
  assign page    = i_addr[15:16-PAGE_BITS];

`ifdef PAGE_READONLY_EN
  assign we_ok = ~ent_q[RO];
`else
  assign we_ok = 1'b1;
`endif

  assign unused_ok = ^{i_addr[0], ent_q[RO]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
    end else if (i_map_wr) begin
      table_q[i_map_idx] <= i_map_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      off_q          <= '0;
      ent_q          <= '0;
      rdata_q        <= '0;
      we_arm_q       <= 1'b0;
      RAMCS          <= 1'b1;
      RAMOE          <= 1'b1;
      RAMWE          <= 1'b1;
      RAMUB          <= 1'b1;
      RAMLB          <= 1'b1;
      o_dbdir        <= 1'b1;
      o_sram_oe_data <= 1'b0;
      o_sram_addr    <= '0;
      o_sram_data    <= '0;
    end else begin
      // A byte write is armed only after we has been seen high, so one long we-low writes once.
      if (we_s) we_arm_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (!memen_s) state_q <= S_WAIT_ADDR;
        end
        S_WAIT_ADDR: begin
          if (i_addr_valid) begin
            off_q   <= i_addr[15-PAGE_BITS:1];
            ent_q   <= table_q[page];
            state_q <= S_DECODE;
          end else if (memen_s) begin
            state_q <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (!ent_q[VLD]) begin
            state_q <= S_HOLD;
          end else begin
            RAMCS       <= 1'b0;
            o_sram_addr <= {ent_q[PHYS_BITS-1:0], off_q};
            cnt_q       <= '0;
            if (dbin_s) begin
              RAMOE   <= 1'b0;
              state_q <= S_READ;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_READ: begin
          if (cnt_q == RD_LAST) begin
            rdata_q <= i_sram_data;
            RAMOE   <= 1'b1;
            RAMCS   <= 1'b1;
            o_dbdir <= 1'b0;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WRITE: begin
          if (memen_s) begin
            RAMCS   <= 1'b1;
            state_q <= S_HOLD;
          end else if (!we_s && we_arm_q) begin
            we_arm_q       <= 1'b0;
            o_sram_data    <= {i_data_bus, i_data_bus};
            RAMUB          <= a15_s;
            RAMLB          <= ~a15_s;
            o_sram_oe_data <= 1'b1;
            RAMWE          <= ~we_ok;
            cnt_q          <= '0;
            state_q        <= S_WPULSE;
          end
        end
        S_WPULSE: begin
          if (cnt_q == PULSE_END) begin
            RAMUB          <= 1'b1;
            RAMLB          <= 1'b1;
            o_sram_oe_data <= 1'b0;
            state_q        <= S_WRITE;
          end else begin
            if (cnt_q == PULSE_LAST) RAMWE <= 1'b1;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          RAMCS <= 1'b1;
          RAMOE <= 1'b1;
          RAMWE <= 1'b1;
          RAMUB <= 1'b1;
          RAMLB <= 1'b1;
          if (memen_s) begin
            o_dbdir <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data_bus = o_dbdir ? 8'h00 : (a15_s ? rdata_q[7:0] : rdata_q[15:8]);
  assign o_busy     = (state_q != S_IDLE);
  assign o_state    = state_q;

endmodule
`default_nettype wire
